// File: rtl/sram_like_responder.sv
// ---------------------------------------------------------------------------
// sram_like_responder
//
// Memory-side responder for an SRAM-like bus. Requests are accepted into an
// in-order queue. Each entry carries a ready countdown. Entries retire
// strictly in order, at most one per cycle, and return a one-cycle data_ok
// strobe. Reads also return the aligned word on rdata.
//
// Parameters
//   MEM_WORDS : words in the backing store (power of two)
//   LATENCY   : cycles from accept to data_ok sample edge (1..15)
//   QDEPTH    : maximum outstanding requests (power of two, >= 2)
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous reset, active low
//   req      in   request valid
//   wr       in   1 = write, 0 = read
//   size     in   0 byte, 1 halfword, 2/3 word
//   addr     in   byte address (upper bits ignored, space wraps)
//   wdata    in   write data in its byte lanes
//   addr_ok  out  request accepted at the next edge when req is high
//   data_ok  out  one-cycle response strobe (registered)
//   rdata    out  read data while data_ok is high, otherwise 0 (registered)
//
// Configuration
//   SRAM_RESP_RANDOM_DELAY_EN : when defined, a 16-bit LFSR adds 0..3 extra
//   cycles to each accepted request's countdown.
// ---------------------------------------------------------------------------
module sram_like_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2,
    parameter int QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = 5;  // holds LATENCY + 3 extra cycles

    // Byte lanes written by an access; misaligned accesses write nothing.
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (sz)
            2'd0: be = 4'b0001 << a;
            2'd1: if (!a[0]) be = a[1] ? 4'b1100 : 4'b0011;
            default: if (a == 2'b00) be = 4'b1111;
        endcase
        return be;
    endfunction

    logic          r_q_wr    [QDEPTH];
    logic [1:0]    r_q_size  [QDEPTH];
    logic [AW+1:0] r_q_addr  [QDEPTH];
    logic [31:0]   r_q_wdata [QDEPTH];
    logic [CW-1:0] r_q_cnt   [QDEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          r_data_ok;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem     [MEM_WORDS];

    logic [CW-1:0] w_load;
    logic [PW:0]   w_occ;
    logic          w_accept;
    logic          w_head_ret;
    logic          w_byp;
    logic          w_retire;
    logic          w_enq;
    logic          w_ret_wr;
    logic [1:0]    w_ret_size;
    logic [AW+1:0] w_ret_addr;
    logic [31:0]   w_ret_wdata;
    logic [AW-1:0] w_ret_idx;
    logic [3:0]    w_ret_be;
    logic [31:0]   w_rd_word;

`ifdef SRAM_RESP_RANDOM_DELAY_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_load = CW'(LATENCY) + CW'(r_lfsr[1:0]);
`else
    assign w_load = CW'(LATENCY);
`endif

    // The entry presenting data_ok still counts as outstanding, so a full
    // queue only reopens the cycle after that strobe.
    assign w_occ   = r_count + {{PW{1'b0}}, r_data_ok};
    assign addr_ok = reset && (w_occ < (PW+1)'(QDEPTH));

    assign w_accept = req && addr_ok;

    // Stored countdown is (load - 1), so the head retires on the edge at
    // which its remaining count is <= 1. A load of 1 into an empty queue
    // must retire on the accept edge itself, which bypasses the queue.
    assign w_head_ret = (r_count != '0) && (r_q_cnt[r_head] <= CW'(1));
    assign w_byp      = w_accept && (r_count == '0) && (w_load == CW'(1));
    assign w_retire   = w_head_ret || w_byp;
    assign w_enq      = w_accept && !w_byp;

    assign w_ret_wr    = w_head_ret ? r_q_wr[r_head]    : wr;
    assign w_ret_size  = w_head_ret ? r_q_size[r_head]  : size;
    assign w_ret_addr  = w_head_ret ? r_q_addr[r_head]  : addr[AW+1:0];
    assign w_ret_wdata = w_head_ret ? r_q_wdata[r_head] : wdata;
    assign w_ret_idx   = w_ret_addr[AW+1:2];
    assign w_ret_be    = byte_en(w_ret_size, w_ret_addr[1:0]);
    assign w_rd_word   = r_mem[w_ret_idx];

    // Control state and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_data_ok <= w_retire;
            r_rdata   <= (w_retire && !w_ret_wr) ? w_rd_word : 32'd0;
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_head_ret) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_head_ret})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue payload and countdowns; meaningful only for occupied slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (r_q_cnt[i] != '0) begin
                r_q_cnt[i] <= r_q_cnt[i] - CW'(1);
            end
        end
        if (w_enq) begin
            r_q_wr[r_tail]    <= wr;
            r_q_size[r_tail]  <= size;
            r_q_addr[r_tail]  <= addr[AW+1:0];
            r_q_wdata[r_tail] <= wdata;
            r_q_cnt[r_tail]   <= w_load - CW'(1);
        end
    end

    // Backing store, written on the edge the write retires; not reset.
    always_ff @(posedge clk) begin
        if (w_retire && w_ret_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_ret_be[b]) begin
                    r_mem[w_ret_idx][8*b +: 8] <= w_ret_wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_ok = r_data_ok;
    assign rdata   = r_rdata;

endmodule
